bcd_count_ctrl: RTL
===================

# bcd_count_ctrl

Sequencer for a 3-digit packed-BCD (000–999) event/stopwatch counter. It owns a prescaler, a run/pause/done state machine, load and clear commands and terminal-count handling, and advances the BCD value by one on each prescaler step. It sits between the board's button/command logic and the 7-segment display path, which consumes `count` directly.

## Interface
Parameters:
- `DIV`, default 100000: prescaler period in `clk` cycles per count step. Legal range is DIV ≥ 1; DIV = 1 steps every cycle.

Ports:
- `clk`  in  1: single clock; every register is rising-edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `start`  in  1: level or pulse; sampled each cycle.
- `stop`  in  1: pause request.
- `clear`  in  1: zero the count and the prescaler.
- `load`  in  1: load `load_val`.
- `load_val`  in  12: packed BCD `{hundreds, tens, ones}`.
- `limit`  in  12: packed BCD terminal value. Used only with `BCD_CTRL_LIMIT_EN`.
- `wrap_en`  in  1: 1 selects wrap 999→000; 0 selects saturate at 999.
- `count`  out  12: current packed-BCD value.
- `running`  out  1: high in RUN.
- `done`  out  1: high in DONE.
- `ovf`  out  1: one-cycle pulse on wrap 999→000.
- `load_err`  out  1: one-cycle pulse when a load is rejected.

## Operation
- States: IDLE, RUN, PAUSE, DONE.
  - IDLE→RUN on `start`.
  - RUN→PAUSE on `stop`.
  - PAUSE→RUN on `start`.
  - RUN→DONE on a terminal event.
  - DONE→IDLE on `clear` or an accepted `load`.
- Command priority within one cycle, highest first: `clear` > `load` > `stop` > `start`.
- `clear`, from any state: `count` = 000, prescaler = 0, state = IDLE.
- `load`, from any state:
  - Every nibble of `load_val` must be ≤ 9.
  - If valid: `count` = `load_val`, prescaler = 0, state = IDLE.
  - If any nibble is > 9: `count` and state are unchanged, and `load_err` pulses.
- Prescaler:
  - Counts only in RUN.
  - Wraps from DIV−1 to 0 and emits an internal `step` on that cycle.
  - Holds its value in PAUSE, so a paused partial interval is resumed, not restarted.
- On `step`, `count` becomes the BCD increment: ones carry into tens, tens carry into hundreds.
- Terminal events on `step`:
  - At 999 with `wrap_en` = 1: `count` = 000, `ovf` pulses, and the block stays in RUN.
  - At 999 with `wrap_en` = 0: `count` holds 999 and the state goes to DONE. `ovf` does not pulse.
- Simultaneous events:
  - A `stop` in the same cycle as `step` still applies that step, then enters PAUSE.
  - A `clear` or `load` in the same cycle as `step` wins; the step is discarded.
  - `start` in RUN or DONE is ignored. `stop` outside RUN is ignored.

## Timing
- Reset values: `count` = 000, state = IDLE, prescaler = 0, and `running`, `done`, `ovf`, `load_err` all 0.
- All outputs are registered.
- `start` asserted in cycle N: `running` = 1 in N+1. The first `count` change is visible at N+DIV+1, and every DIV cycles after that.
- `clear` or `load` asserted in cycle N: the new `count` is visible in N+1.
- `ovf` and `load_err` are high for exactly one cycle.
- `done` stays high until `clear` or an accepted `load`.
- If `rst_n` is asserted mid-count, all state is lost immediately. There is no resume after reset.

## Configuration
- `BCD_CTRL_LIMIT_EN` defined:
  - On each `step`, the incremented value is compared with `limit`.
  - On a match, `count` takes the new value, the state goes to DONE, and `done` rises in the next cycle.
  - The limit match has priority over the 999 wrap/saturate handling when `limit` = 999.
  - A `limit` with any nibble > 9 never matches.
- `BCD_CTRL_LIMIT_EN` undefined:
  - The `limit` port is present but ignored.
  - The only terminal event is saturation at 999 with `wrap_en` = 0.

## Structure
- Shared package `bcd_pkg` holds:
  - the state enum `{S_IDLE, S_RUN, S_PAUSE, S_DONE}`;
  - the constants `BCD_MAX_DIGIT` = 4'd9 and `BCD_MAX` = 12'h999;
  - a `bcd_valid` function that checks all three nibbles of a 12-bit value.
- One sub-module, `bcd_digit_inc`: 4-bit combinational digit increment.
  - Inputs: `d`, `cin`. Outputs: `q`, `cout`.
  - Behaviour: `q` = `d` + `cin`, with 9+1 giving 0 and `cout` = 1.
  - Three instances are chained: ones, tens, hundreds.
- Prescaler width is `$clog2(DIV)`, minimum 1.

## Test plan
Use DIV = 4 in simulation.
- Reset, then `start` for 1 cycle → `running` = 1 next cycle; `count` = 001 four cycles later, then 002, 003 at 4-cycle spacing.
- Load 12'h098, `start`, run 2 steps → `count` reads 099 then 100; nibble carries are correct.
- Load 12'h999, `wrap_en` = 1, `start` → one step gives 000 with a single `ovf` pulse and `running` still 1. With `wrap_en` = 0, `count` holds 999, `done` = 1, and `ovf` = 0.
- `stop` asserted 2 cycles into an interval, hold 10 cycles, then `start` → the next step arrives 2 cycles after resume, not 4.
- Load 12'h0A5 while `count` = 123 → `load_err` pulses for one cycle; `count` stays 123 and the state is unchanged. A `clear` and `load` in the same cycle → `count` = 000.
- With `BCD_CTRL_LIMIT_EN` and `limit` = 12'h005: `start` from 000 → `done` = 1 with `count` = 005 after 5 steps. `clear` then gives IDLE with `count` = 000.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and helpers for the 3-digit packed-BCD counter.
// Imported by bcd_digit_inc and bcd_count_ctrl.
package bcd_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_PAUSE,
      S_DONE
   } state_t;

   localparam logic [3:0]  BCD_MAX_DIGIT = 4'd9;
   localparam logic [11:0] BCD_MAX       = 12'h999;

   function automatic logic bcd_valid(input logic [11:0] v);
      return (v[3:0]  <= BCD_MAX_DIGIT) &&
             (v[7:4]  <= BCD_MAX_DIGIT) &&
             (v[11:8] <= BCD_MAX_DIGIT);
   endfunction

endpackage

// File: rtl/bcd_digit_inc.sv
// Single BCD digit incrementer: 9 + carry-in rolls to 0
// and raises carry-out into the next digit.
module bcd_digit_inc
   import bcd_pkg::*;
(
   input  logic [3:0] d,
   input  logic       cin,
   output logic [3:0] q,
   output logic       cout
);

   assign cout = cin && (d == BCD_MAX_DIGIT);
   assign q    = cout ? 4'd0 : d + {3'b000, cin};

endmodule

// File: rtl/bcd_count_ctrl.sv
// Run/pause/done sequencer for a 000-999 packed-BCD counter.
// Define BCD_CTRL_LIMIT_EN to enable the programmable terminal value.
module bcd_count_ctrl
   import bcd_pkg::*;
#(
   parameter int unsigned DIV = 100000
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        stop,
   input  logic        clear,
   input  logic        load,
   input  logic [11:0] load_val,
   input  logic [11:0] limit,
   input  logic        wrap_en,
   output logic [11:0] count,
   output logic        running,
   output logic        done,
   output logic        ovf,
   output logic        load_err
);

   localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

   state_t        state_q, state_d;
   logic [11:0]   count_q, count_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          running_q, done_q, ovf_q, ovf_d;
   logic          lerr_q, lerr_d;

   logic [11:0] inc;
   logic        o_c, t_c, h_c;
   logic        lim_hit;

   bcd_digit_inc u_ones (
      .d    (count_q[3:0]),
      .cin  (1'b1),
      .q    (inc[3:0]),
      .cout (o_c)
   );

   bcd_digit_inc u_tens (
      .d    (count_q[7:4]),
      .cin  (o_c),
      .q    (inc[7:4]),
      .cout (t_c)
   );

   bcd_digit_inc u_hund (
      .d    (count_q[11:8]),
      .cin  (t_c),
      .q    (inc[11:8]),
      .cout (h_c)
   );

`ifdef BCD_CTRL_LIMIT_EN
   assign lim_hit = bcd_valid(limit) && (inc == limit);
`else
   logic unused_limit;
   assign unused_limit = ^limit;
   assign lim_hit      = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      presc_d = presc_q;
      ovf_d   = 1'b0;
      lerr_d  = 1'b0;
      if (clear) begin
         count_d = '0;
         presc_d = '0;
         state_d = S_IDLE;
      end else if (load) begin
         // A rejected load freezes everything for this cycle.
         if (bcd_valid(load_val)) begin
            count_d = load_val;
            presc_d = '0;
            state_d = S_IDLE;
         end else begin
            lerr_d = 1'b1;
         end
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (start) state_d = S_RUN;
            end
            S_RUN: begin
               if (presc_q == PMAX) begin
                  presc_d = '0;
                  if (lim_hit) begin
                     count_d = inc;
                     state_d = S_DONE;
                  end else if (!h_c) begin
                     count_d = inc;
                  end else if (wrap_en) begin
                     count_d = '0;
                     ovf_d   = 1'b1;
                  end else begin
                     state_d = S_DONE;
                  end
               end else begin
                  presc_d = presc_q + PW'(1);
               end
               if (stop && state_d == S_RUN) state_d = S_PAUSE;
            end
            S_PAUSE: begin
               if (start) state_d = S_RUN;
            end
            S_DONE: begin
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         count_q   <= '0;
         presc_q   <= '0;
         running_q <= 1'b0;
         done_q    <= 1'b0;
         ovf_q     <= 1'b0;
         lerr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         presc_q   <= presc_d;
         running_q <= (state_d == S_RUN);
         done_q    <= (state_d == S_DONE);
         ovf_q     <= ovf_d;
         lerr_q    <= lerr_d;
      end
   end

   assign count    = count_q;
   assign running  = running_q;
   assign done     = done_q;
   assign ovf      = ovf_q;
   assign load_err = lerr_q;

endmodule
